// File: rtl/alu_operand_stage_pkg.sv
// Shared CPU definitions for the ID/EX operand stage: ALU op codes, register-zero
// index, forward-select and stage-update encodings.
package alu_operand_stage_pkg;

    localparam logic [4:0] ALU_AND = 5'd0;
    localparam logic [4:0] ALU_OR  = 5'd1;
    localparam logic [4:0] ALU_ADD = 5'd2;
    localparam logic [4:0] ALU_SUB = 5'd6;
    localparam logic [4:0] ALU_SLT = 5'd7;
    localparam logic [4:0] ALU_NOR = 5'd12;
    localparam logic [4:0] ALU_XOR = 5'd13;
    localparam logic [4:0] ALU_SLL = 5'd16;
    localparam logic [4:0] ALU_SRL = 5'd24;
    localparam logic [4:0] ALU_SRA = 5'd25;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_BUBBLE = 2'd2
    } upd_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, hazard controls, forwarding sources
// and EX-side outputs. ALU_STAGE_STATS_EN adds the stat_bubbles/stat_fwd counters.
interface alu_operand_stage_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic [4:0]            id_shamt;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_uses_rt;
    logic [4:0]            id_alu_ctl;
    logic                  id_sign;
    logic                  id_src_a_shamt;
    logic                  id_src_b_imm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_to_reg;
    logic                  stall;
    logic                  flush;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_dest;
    logic [DATA_W-1:0]     exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_dest;
    logic [DATA_W-1:0]     memwb_result;
    logic [DATA_W-1:0]     alu_in1;
    logic [DATA_W-1:0]     alu_in2;
    logic [4:0]            alu_ctl;
    logic                  alu_sign;
    logic [DATA_W-1:0]     ex_store_data;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;
    logic                  load_use_stall;
`ifdef ALU_STAGE_STATS_EN
    logic [31:0]           stat_bubbles;
    logic [31:0]           stat_fwd;
`endif

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_dest, id_uses_rt, id_alu_ctl, id_sign,
               id_src_a_shamt, id_src_b_imm, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, stall, flush,
               exmem_reg_write, exmem_dest, exmem_result,
               memwb_reg_write, memwb_dest, memwb_result,
        input
`ifdef ALU_STAGE_STATS_EN
               stat_bubbles, stat_fwd,
`endif
               alu_in1, alu_in2, alu_ctl, alu_sign, ex_store_data, ex_dest,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_dest, id_uses_rt, id_alu_ctl, id_sign,
               id_src_a_shamt, id_src_b_imm, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, stall, flush,
               exmem_reg_write, exmem_dest, exmem_result,
               memwb_reg_write, memwb_dest, memwb_result,
        output
`ifdef ALU_STAGE_STATS_EN
               stat_bubbles, stat_fwd,
`endif
               alu_in1, alu_in2, alu_ctl, alu_sign, ex_store_data, ex_dest,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, load_use_stall
    );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-source forwarding mux: EX/MEM beats MEM/WB beats register-file data;
// register 0 never matches a producer.
module fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic [DATA_W-1:0]     i_rf_data,
    input  logic                  i_exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_exmem_dest,
    input  logic [DATA_W-1:0]     i_exmem_result,
    input  logic                  i_memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_memwb_dest,
    input  logic [DATA_W-1:0]     i_memwb_result,
    output logic [DATA_W-1:0]     o_data,
    output fwd_sel_e              o_sel
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_reg_write
                       && (i_exmem_dest != REG_ADDR_W'(REG_ZERO))
                       && (i_exmem_dest == i_src);
    assign w_memwb_hit = i_memwb_reg_write
                       && (i_memwb_dest != REG_ADDR_W'(REG_ZERO))
                       && (i_memwb_dest == i_src);

    always_comb begin
        o_sel  = FWD_RF;
        o_data = i_rf_data;
        if (w_exmem_hit) begin
            o_sel  = FWD_EXMEM;
            o_data = i_exmem_result;
        end else if (w_memwb_hit) begin
            o_sel  = FWD_MEMWB;
            o_data = i_memwb_result;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble
// insertion. ALU_STAGE_STATS_EN adds bubble/forward event counters.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [4:0]            shamt;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [4:0]            alu_ctl;
        logic                  sign;
        logic                  src_a_shamt;
        logic                  src_b_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } idex_t;

    idex_t             r_ex;
    idex_t             w_id;
    upd_e              w_upd;
    logic              w_load_use;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    fwd_sel_e          w_sel_rs;
    fwd_sel_e          w_sel_rt;

    // r_ex.mem_read is already qualified by valid at load time
    assign w_load_use = r_ex.valid && r_ex.mem_read
                      && (r_ex.dest != REG_ADDR_W'(REG_ZERO))
                      && ((r_ex.dest == bus.id_rs)
                          || (bus.id_uses_rt && (r_ex.dest == bus.id_rt)))
                      && bus.id_valid;

    always_comb begin
        w_upd = UPD_LOAD;
        if (bus.flush) begin
            w_upd = UPD_BUBBLE;
        end else if (bus.stall) begin
            w_upd = UPD_HOLD;
        end else if (w_load_use) begin
            w_upd = UPD_BUBBLE;
        end
    end

    always_comb begin
        w_id             = '0;
        w_id.valid       = bus.id_valid;
        w_id.rs_data     = bus.id_rs_data;
        w_id.rt_data     = bus.id_rt_data;
        w_id.imm         = bus.id_imm;
        w_id.shamt       = bus.id_shamt;
        w_id.rs          = bus.id_rs;
        w_id.rt          = bus.id_rt;
        w_id.dest        = bus.id_dest;
        w_id.alu_ctl     = bus.id_alu_ctl;
        w_id.sign        = bus.id_sign;
        w_id.src_a_shamt = bus.id_src_a_shamt;
        w_id.src_b_imm   = bus.id_src_b_imm;
        w_id.reg_write   = bus.id_reg_write  & bus.id_valid;
        w_id.mem_read    = bus.id_mem_read   & bus.id_valid;
        w_id.mem_write   = bus.id_mem_write  & bus.id_valid;
        w_id.mem_to_reg  = bus.id_mem_to_reg & bus.id_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex <= '0;
        end else begin
            case (w_upd)
                UPD_BUBBLE: r_ex <= '0;
                UPD_HOLD:   r_ex <= r_ex;
                default:    r_ex <= w_id;
            endcase
        end
    end

    fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs (
        .i_src             (r_ex.rs),
        .i_rf_data         (r_ex.rs_data),
        .i_exmem_reg_write (bus.exmem_reg_write),
        .i_exmem_dest      (bus.exmem_dest),
        .i_exmem_result    (bus.exmem_result),
        .i_memwb_reg_write (bus.memwb_reg_write),
        .i_memwb_dest      (bus.memwb_dest),
        .i_memwb_result    (bus.memwb_result),
        .o_data            (w_fwd_rs),
        .o_sel             (w_sel_rs)
    );

    fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rt (
        .i_src             (r_ex.rt),
        .i_rf_data         (r_ex.rt_data),
        .i_exmem_reg_write (bus.exmem_reg_write),
        .i_exmem_dest      (bus.exmem_dest),
        .i_exmem_result    (bus.exmem_result),
        .i_memwb_reg_write (bus.memwb_reg_write),
        .i_memwb_dest      (bus.memwb_dest),
        .i_memwb_result    (bus.memwb_result),
        .o_data            (w_fwd_rt),
        .o_sel             (w_sel_rt)
    );

    assign bus.alu_in1        = r_ex.src_a_shamt ? DATA_W'(r_ex.shamt) : w_fwd_rs;
    assign bus.alu_in2        = r_ex.src_b_imm ? r_ex.imm : w_fwd_rt;
    assign bus.ex_store_data  = w_fwd_rt;
    assign bus.alu_ctl        = r_ex.alu_ctl;
    assign bus.alu_sign       = r_ex.sign;
    assign bus.ex_dest        = r_ex.dest;
    assign bus.ex_valid       = r_ex.valid;
    assign bus.ex_reg_write   = r_ex.reg_write;
    assign bus.ex_mem_read    = r_ex.mem_read;
    assign bus.ex_mem_write   = r_ex.mem_write;
    assign bus.ex_mem_to_reg  = r_ex.mem_to_reg;
    assign bus.load_use_stall = w_load_use;

`ifdef ALU_STAGE_STATS_EN
    logic [31:0] r_stat_bubbles;
    logic [31:0] r_stat_fwd;
    logic [1:0]  w_fwd_cnt;

    assign w_fwd_cnt = {1'b0, (w_sel_rs != FWD_RF)} + {1'b0, (w_sel_rt != FWD_RF)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_bubbles <= '0;
            r_stat_fwd     <= '0;
        end else begin
            if (!bus.flush && !bus.stall && w_load_use) begin
                r_stat_bubbles <= r_stat_bubbles + 32'd1;
            end
            if (r_ex.valid && !bus.stall) begin
                r_stat_fwd <= r_stat_fwd + 32'(w_fwd_cnt);
            end
        end
    end

    assign bus.stat_bubbles = r_stat_bubbles;
    assign bus.stat_fwd     = r_stat_fwd;
`else
    logic w_unused_sel;
    assign w_unused_sel = ^{w_sel_rs, w_sel_rt};
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed hazard scenarios followed by
// randomized traffic against a behavioural ID/EX model.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus();

    alu_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rs, rt, dest, ctl;
        logic        sign, src_a, src_b, rw, mr, mw, m2r;
    } ex_t;

    ex_t m;
    int  n_checks = 0;
    int  n_errors = 0;
`ifdef ALU_STAGE_STATS_EN
    logic [31:0] m_bubbles = '0;
    logic [31:0] m_fwd     = '0;
`endif

    function automatic ex_t ex_zero();
        ex_t z;
        z.valid = 0; z.rs_data = 0; z.rt_data = 0; z.imm = 0;
        z.shamt = 0; z.rs = 0; z.rt = 0; z.dest = 0; z.ctl = 0;
        z.sign = 0; z.src_a = 0; z.src_b = 0;
        z.rw = 0; z.mr = 0; z.mw = 0; z.m2r = 0;
        return z;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    // Value a source register really holds from EX's point of view
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (hit(bus.exmem_reg_write, bus.exmem_dest, src)) return bus.exmem_result;
        if (hit(bus.memwb_reg_write, bus.memwb_dest, src)) return bus.memwb_result;
        return rf;
    endfunction

    function automatic logic exp_lus();
        return m.valid && m.mr && (m.dest != 5'd0) && bus.id_valid
            && ((m.dest == bus.id_rs) || (bus.id_uses_rt && (m.dest == bus.id_rt)));
    endfunction

    task automatic check_all(input string s);
        logic [31:0] f_rs, f_rt;
        f_rs = fwd(m.rs, m.rs_data);
        f_rt = fwd(m.rt, m.rt_data);
        chk({s, ":alu_in1"}, bus.alu_in1, m.src_a ? {27'd0, m.shamt} : f_rs);
        chk({s, ":alu_in2"}, bus.alu_in2, m.src_b ? m.imm : f_rt);
        chk({s, ":store"},   bus.ex_store_data, f_rt);
        chk({s, ":ctl"},     32'(bus.alu_ctl), 32'(m.ctl));
        chk({s, ":sign"},    32'(bus.alu_sign), 32'(m.sign));
        chk({s, ":dest"},    32'(bus.ex_dest), 32'(m.dest));
        chk({s, ":valid"},   32'(bus.ex_valid), 32'(m.valid));
        chk({s, ":ctrl"},
            32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
            32'({m.rw, m.mr, m.mw, m.m2r}));
        chk({s, ":lus"},     32'(bus.load_use_stall), 32'(exp_lus()));
    endtask

    task automatic tick();
        logic lus;
        lus = exp_lus();
`ifdef ALU_STAGE_STATS_EN
        if (reset) begin
            m_bubbles = '0;
            m_fwd     = '0;
        end else begin
            if (!bus.flush && !bus.stall && lus) m_bubbles = m_bubbles + 1;
            if (m.valid && !bus.stall)
                m_fwd = m_fwd
                      + 32'(hit(bus.exmem_reg_write, bus.exmem_dest, m.rs) || hit(bus.memwb_reg_write, bus.memwb_dest, m.rs))
                      + 32'(hit(bus.exmem_reg_write, bus.exmem_dest, m.rt) || hit(bus.memwb_reg_write, bus.memwb_dest, m.rt));
        end
`endif
        @(posedge clk);
        if (reset || bus.flush) begin
            m = ex_zero();
        end else if (bus.stall) begin
            m = m;
        end else if (lus) begin
            m = ex_zero();
        end else begin
            m.valid   = bus.id_valid;
            m.rs_data = bus.id_rs_data;  m.rt_data = bus.id_rt_data;
            m.imm     = bus.id_imm;      m.shamt   = bus.id_shamt;
            m.rs      = bus.id_rs;       m.rt      = bus.id_rt;
            m.dest    = bus.id_dest;     m.ctl     = bus.id_alu_ctl;
            m.sign    = bus.id_sign;
            m.src_a   = bus.id_src_a_shamt;
            m.src_b   = bus.id_src_b_imm;
            m.rw      = bus.id_reg_write  && bus.id_valid;
            m.mr      = bus.id_mem_read   && bus.id_valid;
            m.mw      = bus.id_mem_write  && bus.id_valid;
            m.m2r     = bus.id_mem_to_reg && bus.id_valid;
        end
        #1;
    endtask

    task automatic id_nop();
        bus.id_valid = 0; bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
        bus.id_shamt = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_dest = '0;
        bus.id_uses_rt = 0; bus.id_alu_ctl = ALU_AND; bus.id_sign = 0;
        bus.id_src_a_shamt = 0; bus.id_src_b_imm = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    endtask

    task automatic fwd_none();
        bus.exmem_reg_write = 0; bus.exmem_dest = '0; bus.exmem_result = '0;
        bus.memwb_reg_write = 0; bus.memwb_dest = '0; bus.memwb_result = '0;
    endtask

    task automatic id_add_1_2();
        id_nop();
        bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_dest = 5'd4;
        bus.id_rs_data = 32'd5; bus.id_rt_data = 32'd7; bus.id_uses_rt = 1;
        bus.id_alu_ctl = ALU_ADD; bus.id_reg_write = 1;
    endtask

    initial begin
        m = ex_zero();
        reset = 1; bus.stall = 0; bus.flush = 0;
        id_nop(); fwd_none();
        tick(); tick();
        check_all("reset");
        chk("reset_in1", bus.alu_in1, 32'd0);
        chk("reset_valid", 32'(bus.ex_valid), 32'd0);
        reset = 0;

        // 1: plain ADD
        id_add_1_2();
        tick();
        check_all("t1");
        chk("t1_in1", bus.alu_in1, 32'd5);
        chk("t1_in2", bus.alu_in2, 32'd7);
        chk("t1_ctl", 32'(bus.alu_ctl), 32'd2);
        chk("t1_valid", 32'(bus.ex_valid), 32'd1);

        // 2: forwarding priority and register-0 exclusion
        bus.stall = 1;
        bus.exmem_reg_write = 1; bus.exmem_dest = 5'd1; bus.exmem_result = 32'h100;
        bus.memwb_reg_write = 1; bus.memwb_dest = 5'd1; bus.memwb_result = 32'h200;
        #1;
        check_all("t2a");
        chk("t2_exmem_prio", bus.alu_in1, 32'h100);
        bus.exmem_dest = 5'd0; bus.exmem_result = 32'h300;
        #1;
        check_all("t2b");
        chk("t2_zero_dest", bus.alu_in1, 32'h200);
        bus.stall = 0;
        fwd_none();

        // 3: load-use bubble, then MEM/WB forward of the loaded value
        id_nop();
        bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_dest = 5'd3; bus.id_imm = 32'd4;
        bus.id_src_b_imm = 1; bus.id_alu_ctl = ALU_ADD;
        bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1;
        tick();
        id_nop();
        bus.id_valid = 1; bus.id_rs = 5'd3; bus.id_rt = 5'd2; bus.id_dest = 5'd5;
        bus.id_rs_data = 32'h11; bus.id_rt_data = 32'h22; bus.id_uses_rt = 1;
        bus.id_alu_ctl = ALU_SUB; bus.id_reg_write = 1;
        #1;
        check_all("t3a");
        chk("t3_lus", 32'(bus.load_use_stall), 32'd1);
        tick();
        check_all("t3b");
        chk("t3_bubble", 32'(bus.ex_valid), 32'd0);
        bus.memwb_reg_write = 1; bus.memwb_dest = 5'd3; bus.memwb_result = 32'hDEAD;
        tick();
        check_all("t3c");
        chk("t3_fwd", bus.alu_in1, 32'hDEAD);
        chk("t3_ctl", 32'(bus.alu_ctl), 32'd6);
        fwd_none();

        // 4: constant shift and store data forwarding
        id_nop();
        bus.id_valid = 1; bus.id_rt = 5'd2; bus.id_rt_data = 32'd1; bus.id_shamt = 5'd4;
        bus.id_src_a_shamt = 1; bus.id_uses_rt = 1; bus.id_alu_ctl = ALU_SLL;
        bus.id_dest = 5'd6; bus.id_reg_write = 1;
        tick();
        check_all("t4a");
        chk("t4_in1", bus.alu_in1, 32'd4);
        chk("t4_in2", bus.alu_in2, 32'd1);
        chk("t4_ctl", 32'(bus.alu_ctl), 32'd16);
        id_nop();
        bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rs_data = 32'h1000;
        bus.id_rt = 5'd2; bus.id_rt_data = 32'h5; bus.id_imm = 32'd8;
        bus.id_src_b_imm = 1; bus.id_uses_rt = 1; bus.id_mem_write = 1; bus.id_alu_ctl = ALU_ADD;
        tick();
        bus.exmem_reg_write = 1; bus.exmem_dest = 5'd2; bus.exmem_result = 32'hAB;
        #1;
        check_all("t4b");
        chk("t4_in2_imm", bus.alu_in2, 32'd8);
        chk("t4_store", bus.ex_store_data, 32'hAB);
        fwd_none();

        // 5: stall hold, flush over stall, reset over flush
        id_add_1_2();
        tick();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_rs_data = $urandom; bus.id_rs = 5'($urandom_range(0, 31));
            bus.id_alu_ctl = 5'($urandom_range(0, 31));
            tick();
            check_all("t5_stall");
            chk("t5_hold_in1", bus.alu_in1, 32'd5);
        end
        bus.flush = 1;
        tick();
        check_all("t5_flush");
        chk("t5_flush_valid", 32'(bus.ex_valid), 32'd0);
        bus.stall = 0; bus.flush = 0;
        id_add_1_2();
        tick();
        reset = 1; bus.flush = 1;
        tick();
        check_all("t5_reset");
        chk("t5_reset_in2", bus.alu_in2, 32'd0);
        chk("t5_reset_ctl", 32'(bus.alu_ctl), 32'd0);
        reset = 0; bus.flush = 0;

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bus.id_valid       = ($urandom_range(0, 9) < 8);
            bus.id_rs_data     = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
            bus.id_shamt       = 5'($urandom_range(0, 31));
            bus.id_rs          = 5'($urandom_range(0, 3));
            bus.id_rt          = 5'($urandom_range(0, 3));
            bus.id_dest        = 5'($urandom_range(0, 3));
            bus.id_uses_rt     = 1'($urandom_range(0, 1));
            bus.id_alu_ctl     = 5'($urandom_range(0, 31));
            bus.id_sign        = 1'($urandom_range(0, 1));
            bus.id_src_a_shamt = ($urandom_range(0, 3) == 0);
            bus.id_src_b_imm   = 1'($urandom_range(0, 1));
            bus.id_reg_write   = 1'($urandom_range(0, 1));
            bus.id_mem_read    = 1'($urandom_range(0, 1));
            bus.id_mem_write   = 1'($urandom_range(0, 1));
            bus.id_mem_to_reg  = 1'($urandom_range(0, 1));
            bus.stall          = ($urandom_range(0, 9) == 0);
            bus.flush          = ($urandom_range(0, 19) == 0);
            reset              = ($urandom_range(0, 49) == 0);
            bus.exmem_reg_write = 1'($urandom_range(0, 1));
            bus.exmem_dest      = 5'($urandom_range(0, 3));
            bus.exmem_result    = $urandom;
            bus.memwb_reg_write = 1'($urandom_range(0, 1));
            bus.memwb_dest      = 5'($urandom_range(0, 3));
            bus.memwb_result    = $urandom;
            #1;
            check_all("rand");
            tick();
        end
        reset = 0; bus.stall = 0; bus.flush = 0;
        #1;
        check_all("rand_end");

`ifdef ALU_STAGE_STATS_EN
        chk("stat_bubbles", bus.stat_bubbles, m_bubbles);
        chk("stat_fwd", bus.stat_fwd, m_fwd);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand-forwarding muxes.
- Latches decoded instruction fields and selects the final in1/in2/ALUCtl/Sign presented to the EX-stage ALU.
- Forwards results from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign/zero-extended immediate
id_shamt  in  5  shift amount
id_rs, id_rt, id_dest  in  REG_ADDR_W  source/destination indices (dest 0 = none)
id_uses_rt  in  1  instruction reads rt as a source
id_alu_ctl  in  5  ALU op code
id_sign  in  1  signed compare
id_src_a_shamt  in  1  in1 = shamt (constant shifts)
id_src_b_imm  in  1  in2 = imm
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
stall  in  1  hold stage (external, e.g. memory wait)
flush  in  1  squash stage (branch/jump taken)
exmem_reg_write  in  1  EX/MEM write enable
exmem_dest  in  REG_ADDR_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB write enable
memwb_dest  in  REG_ADDR_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
alu_in1, alu_in2  out  DATA_W  ALU operands
alu_ctl  out  5  ALU op code
alu_sign  out  1  ALU signed flag
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_dest  out  REG_ADDR_W  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control
load_use_stall  out  1  request ID/IF hold, combinational

Behaviour:
- All registers update on the rising clk edge.
- Update priority: reset > flush > stall > load_use_stall > load.
- Reset: all registered fields 0, so all outputs are 0. alu_ctl=0 (AND) is harmless.
- flush: next cycle is a bubble. Valid and all control bits are 0; data fields don't-care but cleared to 0.
- stall (flush low): all fields hold their value.
- load_use_stall with stall low: insert a bubble, identical to flush. Upstream holds ID, so the instruction re-presents next cycle.
- Otherwise: latch all id_* fields. ex_valid=id_valid. Control bits are ANDed with id_valid.
- load_use_stall = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)) & id_valid.
  - Independent of the stall input.
- Forwarding (combinational from registered rs/rt, per source):
  - EX/MEM hit: exmem_reg_write & exmem_dest!=0 & exmem_dest==src.
  - MEM/WB hit: same form with memwb_* fields.
  - Priority: EX/MEM > MEM/WB > latched register-file data.
  - Register 0 is never forwarded.
- alu_in1 = registered src_a_shamt ? {27'b0, shamt} : fwd_rs.
- alu_in2 = registered src_b_imm ? imm : fwd_rt.
- ex_store_data = fwd_rt always, regardless of src_b_imm.
- alu_ctl and alu_sign are passed straight from the register.
- Bubble cycles: operand outputs are not required to be 0 beyond the reset/flush clearing; consumers qualify on ex_valid.
- Latency: one cycle from ID to alu_* outputs. Forwarded values appear in the same cycle the producer sits in EX/MEM or MEM/WB.
- Reset mid-stall or mid-bubble: reset wins and returns all outputs to 0.

Optional Feature:
- Macro: ALU_STAGE_STATS_EN.
- Defined: adds ports stat_bubbles (out, 32) and stat_fwd (out, 32), both reset to 0.
  - stat_bubbles increments on every cycle a load-use bubble is inserted.
  - stat_fwd increments by 1 per forwarded operand per valid, unstalled EX cycle (0, 1 or 2 per cycle).
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package / header `cpu_defs`:
  - ALU op code constants: AND 0, OR 1, ADD 2, SUB 6, SLT 7, NOR 12, XOR 13, SLL 16, SRL 24, SRA 25.
  - REG_ZERO.
  - Forward-select encoding: FWD_RF, FWD_MEMWB, FWD_EXMEM.
- One natural sub-module, fwd_mux: instantiated twice (rs, rt); implements hit detection and priority, and outputs the selected data and the select code.

Test Plan:
1. Reset, then id_valid=1, ADD rs=$1(5), rt=$2(7), no hazards -> next cycle alu_in1=5, alu_in2=7, alu_ctl=2, ex_valid=1.
2. EX/MEM writes $1=0x100 and MEM/WB writes $1=0x200; EX holds ADD rs=$1 -> alu_in1=0x100. With exmem_dest=0 instead, writing 0x300 -> no forward from it; alu_in1=0x200.
3. EX holds LW dest=$3 (mem_read=1); ID has SUB rs=$3 -> load_use_stall=1; next cycle ex_valid=0. The SUB re-presented then latches, and forwarding from MEM/WB supplies $3.
4. SLL shamt=4 on rt=$2=0x1 with src_a_shamt=1 -> alu_in1=4, alu_in2=1, alu_ctl=16. SW with imm=8 and rt forwarded 0xAB -> alu_in2=8, ex_store_data=0xAB.
5. Assert stall for 3 cycles while ID changes -> outputs unchanged. flush together with stall -> bubble (ex_valid=0). reset together with flush -> all outputs 0.
6. With ALU_STAGE_STATS_EN: two load-use bubbles and one dual-forward instruction -> stat_bubbles=2, stat_fwd=2.
